// File: rtl/apa102_strip_ctrl.sv
// APA102/DotStar strip controller: Wishbone register file plus start/LED/end frame serialiser.
// Optional auto-refresh is compiled in when APA102_AUTO_REFRESH_EN is defined.
module apa102_strip_ctrl #(
  parameter int NUM_LEDS       = 8,
  parameter int CLK_DIV        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  o_led_clk,
  output logic                  o_led_data
);
  localparam int IDX_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int END_WORDS = (NUM_LEDS + 15) / 16;
  localparam logic [8:0]       LAST_LED = 9'(NUM_LEDS - 1);
  localparam logic [8:0]       LAST_END = 9'(END_WORDS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START_FRAME, LED_FRAME, END_FRAME} state_t;

  state_t           state_q, state_d;
  logic [31:0]      shift_q, shift_d;
  logic [4:0]       bit_q, bit_d;
  logic [8:0]       word_q, word_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             led_clk_q, led_clk_d, led_data_q, led_data_d;
  logic             pending_q, pending_d, go_q, go_d;
  logic             ack_q, ack_d, err_q, err_d;
  logic [31:0]      dat_q, dat_d;
  logic [28:0]      led_q [NUM_LEDS];
  logic             auto_q, refresh_fire, launch;

  logic [ADDR_WIDTH-1:0] wrd, led_off;
  logic [IDX_W-1:0]      led_idx;
  logic [8:0]            word_inc;
  logic                  req, ctrl_hit, led_hit, busy, start_wr, led_we;
  logic                  unused_bits;

  assign wrd      = {2'b00, wb_adr_i[ADDR_WIDTH-1:2]};
  assign led_off  = wrd - ADDR_WIDTH'(4);
  assign led_idx  = led_off[IDX_W-1:0];
  assign word_inc = word_q + 9'd1;
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign ctrl_hit = (wrd == '0);
  assign led_hit  = (wrd >= ADDR_WIDTH'(4)) && (wrd < ADDR_WIDTH'(4 + NUM_LEDS));
  assign busy     = (state_q != IDLE);
  assign start_wr = req & wb_we_i & ctrl_hit & wb_sel_i[0] & wb_dat_i[0];
  assign led_we   = req & wb_we_i & led_hit;
  assign unused_bits = ^wb_dat_i[31:29];

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_rty_o   = 1'b0;
  assign wb_dat_o   = dat_q;
  assign o_led_clk  = led_clk_q;
  assign o_led_data = led_data_q;

`ifdef APA102_AUTO_REFRESH_EN
  logic [31:0] refresh_q;
  // The idle counter only runs while AUTO is set and no frame is in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      auto_q    <= 1'b0;
      refresh_q <= '0;
    end else begin
      if (req & wb_we_i & ctrl_hit & wb_sel_i[0]) auto_q <= wb_dat_i[2];
      refresh_q <= (auto_q && !busy && !refresh_fire) ? refresh_q + 32'd1 : '0;
    end
  end
  assign refresh_fire = auto_q && !busy && (refresh_q == 32'(REFRESH_CYCLES - 1));
`else
  assign auto_q       = 1'b0;
  assign refresh_fire = 1'b0;
`endif

  always_comb begin
    ack_d = req & (ctrl_hit | led_hit);
    err_d = req & ~(ctrl_hit | led_hit);
    dat_d = '0;
    if (req && !wb_we_i) begin
      if (ctrl_hit)     dat_d = {28'd0, pending_q, auto_q, busy, 1'b0};
      else if (led_hit) dat_d = {3'b111, led_q[led_idx]};
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    word_d     = word_q;
    div_d      = div_q;
    led_clk_d  = led_clk_q;
    led_data_d = led_data_q;
    pending_d  = pending_q | (start_wr & busy);
    go_d       = start_wr & ~busy;
    launch     = 1'b0;
    if (!busy) begin
      launch = go_q | pending_q | refresh_fire;
    end else if (div_q != LAST_DIV) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      if (!led_clk_q) begin
        led_clk_d = 1'b1;
      end else begin
        led_clk_d = 1'b0;
        if (bit_q != 5'd31) begin
          bit_d   = bit_q + 5'd1;
          shift_d = {shift_q[30:0], 1'b0};
        end else begin
          // Word boundary: each LED word is fetched from its register only now.
          bit_d = '0;
          case (state_q)
            START_FRAME: begin
              state_d = LED_FRAME;
              word_d  = '0;
              shift_d = {3'b111, led_q[0]};
            end
            LED_FRAME: begin
              if (word_q == LAST_LED) begin
                state_d = END_FRAME;
                word_d  = '0;
                shift_d = '1;
              end else begin
                word_d  = word_inc;
                shift_d = {3'b111, led_q[word_inc[IDX_W-1:0]]};
              end
            end
            default: begin
              if (word_q != LAST_END) begin
                word_d  = word_inc;
                shift_d = '1;
              end else if (pending_d) begin
                launch = 1'b1;
              end else begin
                state_d = IDLE;
                shift_d = '0;
              end
            end
          endcase
        end
        led_data_d = shift_d[31];
      end
    end
    if (launch) begin
      state_d    = START_FRAME;
      shift_d    = '0;
      bit_d      = '0;
      word_d     = '0;
      div_d      = '0;
      led_clk_d  = 1'b0;
      led_data_d = 1'b0;
      pending_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      div_q      <= '0;
      led_clk_q  <= 1'b0;
      led_data_q <= 1'b0;
      pending_q  <= 1'b0;
      go_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      div_q      <= div_d;
      led_clk_q  <= led_clk_d;
      led_data_q <= led_data_d;
      pending_q  <= pending_d;
      go_q       <= go_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) led_q[i] <= '0;
    end else if (led_we) begin
      if (wb_sel_i[0]) led_q[led_idx][7:0]   <= wb_dat_i[7:0];
      if (wb_sel_i[1]) led_q[led_idx][15:8]  <= wb_dat_i[15:8];
      if (wb_sel_i[2]) led_q[led_idx][23:16] <= wb_dat_i[23:16];
      if (wb_sel_i[3]) led_q[led_idx][28:24] <= wb_dat_i[28:24];
    end
  end
endmodule

// File: doc/apa102_strip_ctrl.md
Name: apa102_strip_ctrl

Overview:
Parametrised Wishbone-slave controller for APA102/DotStar LED strips; successor to the fixed 8-LED Blinkt bar driver, generalised to NUM_LEDS pixels and a programmable serial clock rate. Holds one 32-bit register per pixel. On command it serialises the full start / LED / end frame sequence onto o_led_clk / o_led_data. Sits on the SerialWishbone bus alongside the other peripheral slaves.

Parameters:
NUM_LEDS, 8, pixel count; legal range 1..256.
CLK_DIV, 2, i_clk cycles per serial half-period; minimum 1.
ADDR_WIDTH, 32, Wishbone address width.
DATA_WIDTH, 32, Wishbone data width; fixed at 32.
REFRESH_CYCLES, 1000000, idle i_clk cycles between auto-refresh frames (optional feature only).

Ports:
i_clk  in  1  system clock.
i_rst_n  in  1  asynchronous, active-low reset.
wb_adr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
wb_dat_i  in  32  write data.
wb_dat_o  out  32  read data.
wb_we_i  in  1  write enable.
wb_sel_i  in  4  byte lane enables.
wb_stb_i  in  1  strobe.
wb_cyc_i  in  1  cycle.
wb_ack_o  out  1  acknowledge.
wb_err_o  out  1  error for unmapped address.
wb_rty_o  out  1  tied 0.
o_led_clk  out  1  strip serial clock.
o_led_data  out  1  strip serial data.

Behaviour:
- Reset: all outputs 0, all registers 0, FSM in IDLE. Asserting reset mid-frame forces o_led_clk/o_led_data low immediately and drops the frame; no partial resume.
- Wishbone classic, single-beat. When cyc&stb&!ack, exactly one of ack/err pulses high for 1 cycle on the next edge. The slave never inserts wait states and never asserts back-to-back acks.
- Register map:
  - 0x00 CTRL: bit0 START (write-1, self-clearing, reads 0); bit1 BUSY (RO); bit2 AUTO (see optional feature); bit3 PENDING (RO).
  - 0x10+4*i, i<NUM_LEDS, LED[i]: [28:24] brightness, [23:16] blue, [15:8] green, [7:0] red; [31:29] read as 3'b111 and ignore writes.
  - Any other address: err pulse instead of ack; writes discarded; wb_dat_o=0.
- Writes honour wb_sel_i per byte lane. Reads return the register value in the ack cycle.
- START with BUSY=0: BUSY=1 on the cycle after ack, and the first data bit is driven that same cycle.
- START with BUSY=1: sets PENDING. The next frame begins the cycle after the current frame ends, and PENDING clears at that point. Multiple pending STARTs collapse to one.
- FSM: IDLE -> START_FRAME (32 zeros) -> LED_FRAME (NUM_LEDS words, LED0 first) -> END_FRAME (32*ceil(NUM_LEDS/16) ones) -> IDLE or START_FRAME (if PENDING).
- Each LED word is sampled from its register when loaded into the shifter, so writes during BUSY take effect for LEDs not yet shifted.
- Bit timing: data is MSB first. o_led_data changes only while o_led_clk is low. Each bit is CLK_DIV cycles low followed by CLK_DIV cycles high; the strip samples on the rising edge.
- In IDLE: o_led_clk=0, o_led_data=0. After the last end-frame bit, o_led_clk returns low.
- Frame length = (32 + 32*NUM_LEDS + 32*ceil(NUM_LEDS/16)) * 2*CLK_DIV i_clk cycles.

Optional Feature:
APA102_AUTO_REFRESH_EN.
- Defined: CTRL.AUTO is R/W. While AUTO=1 and the FSM is IDLE, an internal counter restarts a frame REFRESH_CYCLES cycles after the previous frame ended. Clearing AUTO stops further frames but lets the current frame finish. An explicit START still takes effect immediately.
- Undefined: CTRL.AUTO reads 0 and writes to it are ignored; no refresh counter is instantiated.

Test Plan:
- Reset: hold i_rst_n=0, then release -> all outputs 0, CTRL reads 0x0, LED0 reads 0xE0000000.
- Single frame: NUM_LEDS=8, CLK_DIV=2; write LED0=0x1F0000FF, then START -> serial capture shows 32 zeros, then 0xFF0000FF, then seven words of 0xE0000000, then 32 ones. BUSY stays high for exactly 1280 cycles.
- Byte-lane write: write LED1=0x00AABBCC with sel=4'b0001 -> LED1 reads 0xE00000CC.
- Unmapped access: read address 0x30 (NUM_LEDS=8) -> err=1 for 1 cycle, ack=0. Read 0x04 -> err.
- Start while busy: write START at bit 100 of a frame -> PENDING=1; a second frame starts the cycle after the first ends; total BUSY time is 2560 cycles with no idle gap.
- Mid-frame reset: drop i_rst_n during LED_FRAME -> o_led_clk/o_led_data go 0 with no clock edge. After release BUSY=0 and the LED registers read 0xE0000000.
